// File: rtl/uc_loader.sv
// rtl/uc_loader.sv - host byte-stream loader that writes 16-bit words into the microcode RAM
module uc_loader #(
  parameter bit RUN_ON_LOAD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  uc_addr,
  output logic [15:0] uc_data,
  output logic        uc_we,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GET_ADDR = 3'd1;
  localparam logic [2:0] S_GET_CNT  = 3'd2;
  localparam logic [2:0] S_DATA_LO  = 3'd3;
  localparam logic [2:0] S_DATA_HI  = 3'd4;
  localparam logic [2:0] S_WRITE    = 3'd5;

  localparam logic [7:0] OP_LOAD = 8'h01;
  localparam logic [7:0] OP_RUN  = 8'h02;
  localparam logic [7:0] OP_HALT = 8'h03;

  logic [2:0] state;
  logic [7:0] ptr;
  logic [8:0] cnt;
  logic [7:0] lo_byte;
  logic       done_q;
  logic       err_q;
  logic       accept;

  assign in_ready = ~rst & (state != S_WRITE);
  assign accept   = in_valid & in_ready;
  assign busy     = ~rst & (state != S_IDLE);
  assign uc_we    = ~rst & (state == S_WRITE);
  assign done     = ~rst & done_q;
  assign err      = ~rst & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      core_rst <= 1'b1;
      uc_addr  <= 8'h00;
      uc_data  <= 16'h0000;
      ptr      <= 8'h00;
      cnt      <= 9'd0;
      lo_byte  <= 8'h00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (in_data)
              OP_LOAD: begin
                state    <= S_GET_ADDR;
                core_rst <= 1'b1;
              end
              OP_RUN:  core_rst <= 1'b0;
              OP_HALT: core_rst <= 1'b1;
              default: err_q <= 1'b1;
            endcase
          end
        end
        S_GET_ADDR: begin
          if (accept) begin
            ptr   <= in_data;
            state <= S_GET_CNT;
          end
        end
        S_GET_CNT: begin
          if (accept) begin
            // A count byte of zero encodes a full 256-word load
            cnt   <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
            state <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (accept) begin
            lo_byte <= in_data;
            state   <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (accept) begin
            uc_addr <= ptr;
            uc_data <= {in_data, lo_byte};
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          ptr <= ptr + 8'd1;
          cnt <= cnt - 9'd1;
          if (cnt == 9'd1) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
            if (RUN_ON_LOAD) core_rst <= 1'b0;
          end else begin
            state <= S_DATA_LO;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_loader.sv
// tb/tb_uc_loader.sv - directed self-checking bench for uc_loader
module tb_uc_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        in_ready0, uc_we0, core_rst0, busy0, done0, err0;
  logic [7:0]  uc_addr0;
  logic [15:0] uc_data0;
  logic        in_ready1, uc_we1, core_rst1, busy1, done1, err1;
  logic [7:0]  uc_addr1;
  logic [15:0] uc_data1;

  uc_loader #(.RUN_ON_LOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .uc_addr(uc_addr0), .uc_data(uc_data0), .uc_we(uc_we0), .core_rst(core_rst0),
    .busy(busy0), .done(done0), .err(err0)
  );

  uc_loader #(.RUN_ON_LOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .uc_addr(uc_addr1), .uc_data(uc_data1), .uc_we(uc_we1), .core_rst(core_rst1),
    .busy(busy1), .done(done1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [23:0] wlog[$];
  int busy_bad = 0, ready_bad = 0, we_diff = 0;
  int done0_cnt = 0, done1_cnt = 0, done_rst_bad = 0, err_cnt = 0;
  logic prev_cr1 = 1'b1;

  always @(negedge clk) begin
    if (uc_we0) begin
      wlog.push_back({uc_addr0, uc_data0});
      if (!busy0) busy_bad++;
    end
    if ((uc_we0 && in_ready0) || (uc_we1 && in_ready1)) ready_bad++;
    if (uc_we0 !== uc_we1 || (uc_we0 && {uc_addr0, uc_data0} !== {uc_addr1, uc_data1})) we_diff++;
    if (done0) done0_cnt++;
    if (done1) begin
      done1_cnt++;
      if (!(core_rst1 == 1'b0 && prev_cr1 == 1'b1)) done_rst_bad++;
    end
    if (err0) err_cnt++;
    prev_cr1 = core_rst1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_gap(input logic [7:0] b, input int gaps);
    int bound;
    in_valid = 1'b0;
    repeat (gaps) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    bound = 0;
    while (!in_ready0 && bound < 20) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 20) chk("send_timeout", 32'(in_ready0), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    send_gap(b, 0);
  endtask

  task automatic wait_idle();
    int bound;
    bound = 0;
    while (busy0 && bound < 2000) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 2000) chk("idle_timeout", 32'(busy0), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int bad;
    logic [7:0] cr_before;
    logic [7:0] gap_bytes[9];
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    // A RUN byte presented during reset must be ignored
    in_data = 8'h02; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_core_rst", 32'(core_rst0), 32'd1);
    chk("rst_uc_we",    32'(uc_we0),    32'd0);
    chk("rst_uc_addr",  32'(uc_addr0),  32'h00);
    chk("rst_uc_data",  32'(uc_data0),  32'h0000);
    chk("rst_busy",     32'(busy0),     32'd0);
    chk("rst_done_err", 32'({done0, err0}), 32'd0);
    chk("rst_in_ready", 32'(in_ready0), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_halted", 32'(core_rst0), 32'd1);

    // Two-word load at 0x10
    send(8'h01);
    chk("load_busy", 32'(busy0), 32'd1);
    send(8'h10); send(8'h02); send(8'h34); send(8'h12);
    chk("lat_we",       32'(uc_we0),    32'd1);
    chk("lat_addr",     32'(uc_addr0),  32'h10);
    chk("lat_data",     32'(uc_data0),  32'h1234);
    chk("write_ready0", 32'(in_ready0), 32'd0);
    send(8'hCD); send(8'hAB);
    wait_idle();
    chk("l1_count", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("l1_w0", 32'(wlog[0]), 32'h101234);
      chk("l1_w1", 32'(wlog[1]), 32'h11ABCD);
    end
    chk("l1_done",       32'(done0_cnt), 32'd1);
    chk("l1_core_rst0",  32'(core_rst0), 32'd1);
    chk("l1_core_rst1",  32'(core_rst1), 32'd0);
    chk("hold_addr",     32'(uc_addr0),  32'h11);
    chk("hold_data",     32'(uc_data0),  32'hABCD);
    send(8'h02);
    chk("run_core_rst",  32'(core_rst0), 32'd0);

    // Address wrap from 0xFE
    wlog.delete();
    send(8'h01); send(8'hFE); send(8'h03);
    chk("wrap_core_rst_load", 32'(core_rst0), 32'd1);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    wait_idle();
    chk("wrap_count", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("wrap_w0", 32'(wlog[0]), 32'hFE2211);
      chk("wrap_w1", 32'(wlog[1]), 32'hFF4433);
      chk("wrap_w2", 32'(wlog[2]), 32'h006655);
    end
    chk("wrap_busy_in_write", 32'(busy_bad), 32'd0);

    // Unknown opcode
    send(8'h02);
    wlog.delete();
    cr_before = {7'd0, core_rst0};
    send(8'h7F);
    chk("err_pulse", 32'(err0), 32'd1);
    @(negedge clk);
    chk("err_one_cycle", 32'(err0), 32'd0);
    chk("err_core_rst",  32'(core_rst0), 32'(cr_before));
    chk("err_no_we",     32'(wlog.size()), 32'd0);
    send(8'h03);
    chk("halt_core_rst", 32'(core_rst0), 32'd1);
    send(8'h02);
    chk("err_then_run",  32'(core_rst0), 32'd0);
    chk("err_total",     32'(err_cnt), 32'd1);

    // Reset in the middle of a four-word load
    wlog.delete();
    send(8'h01); send(8'h20); send(8'h04);
    send(8'h01); send(8'h02); send(8'h03);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_core_rst", 32'(core_rst0), 32'd1);
    chk("mid_rst_busy",     32'(busy0), 32'd0);
    repeat (6) @(negedge clk);
    chk("mid_rst_writes",   32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) chk("mid_rst_w0", 32'(wlog[0]), 32'h200201);
    wlog.delete();
    send(8'h01); send(8'h30); send(8'h01); send(8'hAA); send(8'hBB);
    wait_idle();
    chk("fresh_count", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) chk("fresh_w0", 32'(wlog[0]), 32'h30BBAA);

    // Full 256-word load
    wlog.delete();
    done0_cnt = 0;
    send(8'h01); send(8'h00); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      send(8'(i) ^ 8'hA5);
    end
    wait_idle();
    chk("full_count", 32'(wlog.size()), 32'd256);
    bad = 0;
    for (int i = 0; i < wlog.size() && i < 256; i++)
      if (wlog[i] !== {8'(i), 8'(i) ^ 8'hA5, 8'(i)}) bad++;
    chk("full_contents", 32'(bad), 32'd0);
    chk("full_done",     32'(done0_cnt), 32'd1);

    // Gapped load; RUN_ON_LOAD instance releases core on done
    send(8'h03);
    wlog.delete();
    done1_cnt = 0;
    gap_bytes = '{8'h01, 8'h40, 8'h03, 8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB};
    for (int i = 0; i < 9; i++) send_gap(gap_bytes[i], int'($urandom_range(0, 3)));
    wait_idle();
    chk("gap_count", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("gap_w0", 32'(wlog[0]), 32'h404321);
      chk("gap_w1", 32'(wlog[1]), 32'h418765);
      chk("gap_w2", 32'(wlog[2]), 32'h42CBA9);
    end
    chk("gap_done1",        32'(done1_cnt), 32'd1);
    chk("gap_done_rst_edge", 32'(done_rst_bad), 32'd0);
    chk("gap_core_rst1",    32'(core_rst1), 32'd0);
    chk("gap_core_rst0",    32'(core_rst0), 32'd1);
    chk("ready_in_write",   32'(ready_bad), 32'd0);
    chk("dut_we_match",     32'(we_diff), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_loader.md
UC_LOADER -- requirements
Module: uc_loader

Interface
REQ-001 Parameter: RUN_ON_LOAD, default 0, meaning when 1, core_rst deasserts automatically one cycle after the last word of a LOAD is written.
REQ-002 Port: clk  input  1  single clock for all logic; the integrator ties the microcode RAM write clock (uc_clk) to this clock.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_data  input  8  host command/data byte.
REQ-005 Port: in_valid  input  1  in_data is valid.
REQ-006 Port: in_ready  output  1  byte is accepted on the cycle where in_valid and in_ready are both high.
REQ-007 Port: uc_addr  output  8  microcode RAM write address.
REQ-008 Port: uc_data  output  16  microcode RAM write data.
REQ-009 Port: uc_we  output  1  microcode RAM write strobe, one cycle per word.
REQ-010 Port: core_rst  output  1  holds the microcode sequencer (PC) in reset while high.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.
REQ-012 Port: done  output  1  one-cycle pulse after the final word of a LOAD is written.
REQ-013 Port: err  output  1  one-cycle pulse on an unknown opcode.

Function
REQ-014 The FSM SHALL have the states IDLE, GET_ADDR, GET_CNT, DATA_LO, DATA_HI and WRITE.
REQ-015 in_ready SHALL be 1 in every state except WRITE, and 0 while rst is high.
REQ-016 Opcodes accepted in IDLE SHALL be: 0x01 LOAD -> GET_ADDR with core_rst set to 1 in the same clock edge; 0x02 RUN -> core_rst <= 0, stay in IDLE; 0x03 HALT -> core_rst <= 1, stay in IDLE; any other value -> err pulses for 1 cycle, stay in IDLE, and no other output changes.
REQ-017 GET_ADDR SHALL latch the accepted byte into the write pointer and go to GET_CNT.
REQ-018 GET_CNT SHALL latch the word count N (9-bit, byte 0x00 means 256) and go to DATA_LO.
REQ-019 DATA_LO SHALL latch the accepted byte as the low byte and go to DATA_HI; DATA_HI SHALL latch the accepted byte as the high byte and go to WRITE.
REQ-020 Words SHALL be little-endian: uc_data = {high byte, low byte}.
REQ-021 uc_addr and uc_data SHALL be registered and valid in the WRITE cycle, with uc_we = 1 for exactly that cycle.
REQ-022 Write latency SHALL be: uc_we high in the cycle immediately following the clock edge that accepts the high byte.
REQ-023 On leaving WRITE, the pointer SHALL increment modulo 256 (0xFF wraps to 0x00) and the remaining count SHALL decrement.
REQ-024 If the remaining count is nonzero after WRITE, the FSM SHALL go to DATA_LO.
REQ-025 If the remaining count is zero after WRITE, the FSM SHALL go to IDLE with done pulsed for 1 cycle; if RUN_ON_LOAD = 1, core_rst SHALL go to 0 on that same edge.
REQ-026 uc_we SHALL be 0 in every state other than WRITE.
REQ-027 uc_addr and uc_data SHALL hold their last values outside WRITE.
REQ-028 Stalls SHALL be tolerated: any number of in_valid = 0 cycles between bytes has no effect on state.
REQ-029 The host has no abort mechanism; a LOAD completes only after all 2N data bytes are received.
REQ-030 Throughput SHALL be 1 word per 3 cycles when in_valid is held high.

Reset
REQ-031 While rst is high, the block SHALL hold: state = IDLE, core_rst = 1, uc_we = 0, uc_addr = 0x00, uc_data = 0x0000, busy = 0, done = 0, err = 0, in_ready = 0, internal count = 0.
REQ-032 rst asserted mid-LOAD SHALL abandon the load with no further uc_we; words already written remain in the RAM.
REQ-033 A byte presented in the cycle rst is high SHALL be ignored.
REQ-034 After rst deasserts, the core SHALL stay halted until RUN is received (or until a LOAD completes with RUN_ON_LOAD = 1).

Verification
REQ-035 Stream 01 10 02 34 12 CD AB, then 02 -> uc_we pulses with (0x10, 0x1234) then (0x11, 0xABCD); done pulses once; core_rst stays 1 until 02 is sent, then goes 0.
REQ-036 Stream 01 FE 03 followed by 6 data bytes -> writes land at uc_addr 0xFE, 0xFF, 0x00 (wrap); busy is high from the 01 byte through the final WRITE.
REQ-037 Stream 01 00 00 followed by 512 bytes -> exactly 256 uc_we pulses, addresses 0x00..0xFF in order, done pulses once.
REQ-038 Byte 0x7F in IDLE -> err pulses 1 cycle; no uc_we; core_rst unchanged; a following 02 is still accepted normally.
REQ-039 rst pulsed after the low byte of word 2 of a 4-word LOAD -> no further uc_we, core_rst = 1, busy = 0; a fresh LOAD afterwards behaves normally.
REQ-040 Random in_valid gaps with RUN_ON_LOAD = 1 -> same writes as the gap-free run; core_rst falls on the same edge as the done pulse; in_ready is 0 in every WRITE cycle.
